// File: rtl/ce_gen_if.sv
// rtl/ce_gen_if.sv - control inputs and enable strobes of the clock-enable generator
interface ce_gen_if #(
    parameter int CHANNELS = 2
);
    logic                power;
    logic                restart;
    logic [CHANNELS-1:0] hold;
    logic [CHANNELS-1:0] ce_p;
    logic [CHANNELS-1:0] ce_n;
    logic                running;

    modport master (
        input  power,
        input  restart,
        input  hold,
        output ce_p,
        output ce_n,
        output running
    );

    modport slave (
        output power,
        output restart,
        output hold,
        input  ce_p,
        input  ce_n,
        input  running
    );
endinterface

// File: rtl/ce_gen.sv
// rtl/ce_gen.sv - multi-channel fractional clock-enable generator with p/n phase strobes
module ce_gen #(
    parameter int                          CHANNELS = 2,
    parameter int                          ACC_W    = 16,
    parameter logic [CHANNELS*ACC_W-1:0]   NUM      = {16'd1, 16'd1},
    parameter logic [CHANNELS*ACC_W-1:0]   DEN      = {16'd2, 16'd8}
) (
    input logic        clock,
    input logic        reset,
    ce_gen_if.master   bus
);
    logic pwr_meta;
    logic pwr_sync;

    // power comes straight from the PLL lock pin, so it is brought into the clock domain first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwr_meta <= 1'b0;
            pwr_sync <= 1'b0;
        end else begin
            pwr_meta <= bus.power;
            pwr_sync <= pwr_meta;
        end
    end

    assign bus.running = pwr_sync;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [ACC_W-1:0] NUM_I = NUM[i*ACC_W +: ACC_W];
        localparam logic [ACC_W-1:0] DEN_I = DEN[i*ACC_W +: ACC_W];

        if (DEN_I == '0) begin : g_bad_den
            $error("ce_gen: channel %0d has DEN of zero", i);
        end
        if (NUM_I == '0) begin : g_bad_num
            $error("ce_gen: channel %0d has NUM of zero", i);
        end
        if ({NUM_I, 1'b0} > {1'b0, DEN_I}) begin : g_bad_ratio
            $error("ce_gen: channel %0d needs 2*NUM <= DEN", i);
        end

        logic [ACC_W-1:0] acc;
        logic             phase;
        logic             strobe_p;
        logic             strobe_n;
        logic             run;
        logic [ACC_W:0]   sum;

        // stepping by 2*NUM makes each half-period (p to n, n to p) last DEN/(2*NUM) clocks on average
        assign run = pwr_sync & ~bus.hold[i] & ~bus.restart;
        assign sum = {1'b0, acc} + {NUM_I, 1'b0};

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                acc      <= '0;
                phase    <= 1'b0;
                strobe_p <= 1'b0;
                strobe_n <= 1'b0;
            end else if (bus.restart) begin
                acc      <= '0;
                phase    <= 1'b0;
                strobe_p <= 1'b0;
                strobe_n <= 1'b0;
            end else if (run) begin
                if (sum >= {1'b0, DEN_I}) begin
                    acc      <= ACC_W'(sum - {1'b0, DEN_I});
                    phase    <= ~phase;
                    strobe_p <= ~phase;
                    strobe_n <= phase;
                end else begin
                    acc      <= sum[ACC_W-1:0];
                    strobe_p <= 1'b0;
                    strobe_n <= 1'b0;
                end
            end else begin
                strobe_p <= 1'b0;
                strobe_n <= 1'b0;
            end
        end

        assign bus.ce_p[i] = strobe_p;
        assign bus.ce_n[i] = strobe_n;
    end
endmodule

// File: tb/tb_ce_gen.sv
// tb/tb_ce_gen.sv - directed self-checking bench for ce_gen
module tb_ce_gen;
    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       power   = 1'b1;
    logic       restart = 1'b0;
    logic [1:0] hold    = 2'b00;

    int checks = 0;
    int passes = 0;

    int   rc0;
    int   rc1;
    logic pd1;
    logic pd2;

    always #5 clock = ~clock;

    ce_gen_if #(.CHANNELS(2)) bus_a ();
    ce_gen_if #(.CHANNELS(2)) bus_b ();

    assign bus_a.power   = power;
    assign bus_a.restart = restart;
    assign bus_a.hold    = hold;
    assign bus_b.power   = power;
    assign bus_b.restart = restart;
    assign bus_b.hold    = hold;

    ce_gen dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.master)
    );

    ce_gen #(
        .CHANNELS (2),
        .ACC_W    (16),
        .NUM      ({16'd1, 16'd3}),
        .DEN      ({16'd2, 16'd16})
    ) dut_frac (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.master)
    );

    task automatic model_reset();
        rc0 = 0;
        rc1 = 0;
        pd1 = 1'b0;
        pd2 = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        hold    = 2'b00;
        restart = 1'b0;
        power   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Default channels: ch0 = 1/8 gives p at run edge 4 mod 8, n at 0 mod 8; ch1 = 1/2 gives p on odd run edges, n on even.
    task automatic run_edges(input int n, input string tag);
        logic       ep0, en0, ep1, en1, run0, run1;
        logic [4:0] exp_v;
        logic [4:0] got_v;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            run0 = pd2 && !hold[0] && !restart;
            run1 = pd2 && !hold[1] && !restart;
            ep0 = 1'b0; en0 = 1'b0; ep1 = 1'b0; en1 = 1'b0;
            if (restart) begin
                rc0 = 0;
                rc1 = 0;
            end else begin
                if (run0) begin
                    rc0++;
                    ep0 = (rc0 % 8 == 4);
                    en0 = (rc0 % 8 == 0);
                end
                if (run1) begin
                    rc1++;
                    ep1 = (rc1 % 2 == 1);
                    en1 = (rc1 % 2 == 0);
                end
            end
            pd2 = pd1;
            pd1 = power;
            @(negedge clock);
            exp_v = {ep1, ep0, en1, en0, pd2};
            got_v = {bus_a.ce_p, bus_a.ce_n, bus_a.running};
            checks++;
            if (got_v !== exp_v)
                $display("FAIL %s edge %0d: {ce_p,ce_n,running} got %b expected %b", tag, k, got_v, exp_v);
            else
                passes++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        power = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus_a.ce_p, bus_a.ce_n, bus_a.running} !== 5'b0)
            $display("FAIL reset_a: got %b expected 00000", {bus_a.ce_p, bus_a.ce_n, bus_a.running});
        else
            passes++;
        checks++;
        if ({bus_b.ce_p, bus_b.ce_n, bus_b.running} !== 5'b0)
            $display("FAIL reset_b: got %b expected 00000", {bus_b.ce_p, bus_b.ce_n, bus_b.running});
        else
            passes++;
    endtask

    task automatic test_startup();
        do_reset();
        run_edges(24, "startup");
    endtask

    task automatic test_fractional();
        int   cnt_p   = 0;
        int   cnt_n   = 0;
        int   bad_sp  = 0;
        int   bad_alt = 0;
        int   last_p  = -1;
        logic last_was_p = 1'b0;
        logic any_ev     = 1'b0;
        do_reset();
        for (int k = 1; k <= 1602; k++) begin
            @(negedge clock);
            if (bus_b.ce_p[0] && bus_b.ce_n[0]) bad_alt++;
            if (bus_b.ce_p[0]) begin
                cnt_p++;
                if (any_ev && last_was_p) bad_alt++;
                if (last_p >= 0 && !((k - last_p) == 5 || (k - last_p) == 6)) bad_sp++;
                last_p     = k;
                last_was_p = 1'b1;
                any_ev     = 1'b1;
            end
            if (bus_b.ce_n[0]) begin
                cnt_n++;
                if (!any_ev || !last_was_p) bad_alt++;
                last_was_p = 1'b0;
                any_ev     = 1'b1;
            end
        end
        checks++;
        if (cnt_p !== 300) $display("FAIL frac_count_p: got %0d expected 300", cnt_p);
        else passes++;
        checks++;
        if (cnt_n !== 300) $display("FAIL frac_count_n: got %0d expected 300", cnt_n);
        else passes++;
        checks++;
        if (bad_sp !== 0) $display("FAIL frac_spacing: got %0d bad gaps expected 0", bad_sp);
        else passes++;
        checks++;
        if (bad_alt !== 0) $display("FAIL frac_alternate: got %0d violations expected 0", bad_alt);
        else passes++;
    endtask

    task automatic test_hold();
        do_reset();
        run_edges(7, "hold_pre");
        hold = 2'b01;
        run_edges(5, "hold_on");
        hold = 2'b00;
        run_edges(20, "hold_post");
    endtask

    task automatic test_power();
        do_reset();
        run_edges(8, "power_pre");
        power = 1'b0;
        run_edges(3, "power_off");
        power = 1'b1;
        run_edges(24, "power_back");
    endtask

    task automatic test_restart();
        do_reset();
        run_edges(9, "restart_pre");
        restart = 1'b1;
        run_edges(1, "restart_on");
        restart = 1'b0;
        run_edges(12, "restart_post");
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        do_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock);
            if (bus_a.ce_p[0] === 1'b1) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) $display("FAIL async_wait_cep: got %b expected 1", found);
        else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_a.ce_p[0], bus_a.running} !== 2'b00)
            $display("FAIL async_drop: {ce_p0,running} got %b expected 00", {bus_a.ce_p[0], bus_a.running});
        else
            passes++;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_edges(24, "after_async");
    endtask

    initial begin
        test_reset();
        test_startup();
        test_fractional();
        test_hold();
        test_power();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ce_gen.md
Name: ce_gen

Overview:
- Parametrised multi-channel clock-enable generator. It replaces the single fixed divide-by-8 enable counter in board top levels.
- Each channel produces a fractional-rate pair of single-cycle strobes from the system clock:
  - ce_p: the "rising" phase.
  - ce_n: the "falling" phase, half a period after ce_p.
- Sits between the PLL (its locked output drives power) and the cores and video blocks that consume the enables.

Parameters:
- CHANNELS, 2, number of independent enable channels.
- ACC_W, 16, accumulator width per channel.
- NUM, {16'd1,16'd1}, packed CHANNELS*ACC_W vector; channel i numerator in bits [i*ACC_W +: ACC_W].
- DEN, {16'd2,16'd8}, packed CHANNELS*ACC_W vector; channel i denominator, same packing. Defaults give ch0 = 1/8 (2 MHz from 16 MHz) and ch1 = 1/2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- power  input  1  PLL locked, asynchronous to clock; generation runs only while synchronised power is high.
- restart  input  1  synchronous; realigns all channels to phase 0.
- hold  input  CHANNELS  per-channel freeze.
- ce_p  output  CHANNELS  rising-phase strobe, one clock wide.
- ce_n  output  CHANNELS  falling-phase strobe, one clock wide.
- running  output  1  synchronised power.

Behaviour:
- Reset (asynchronous, active-high): acc[i]=0, phase[i]=0, ce_p=0, ce_n=0, power sync flops=0, running=0. This takes effect immediately, including mid-period. After deassert, counting begins only once synchronised power is high.
- Power synchroniser: two flops, so running follows power with 2-clock latency on both edges.
- Per-channel run condition: run[i] = running & ~hold[i] & ~restart.
- Per channel, each clock with run[i]=1:
  - sum = acc + 2*NUM, computed ACC_W+1 bits wide with no overflow.
  - If sum >= DEN: acc <= sum - DEN; phase <= ~phase; ce_p[i] <= ~phase; ce_n[i] <= phase.
  - Otherwise: acc <= sum; ce_p[i] <= 0; ce_n[i] <= 0.
- Result: events alternate p,n,p,n. The long-run ce_p rate is exactly NUM/DEN of clock, and the same holds for ce_n. Jitter is at most 1 clock.
- When run[i]=0:
  - acc and phase hold their value.
  - ce_p[i] and ce_n[i] are driven to 0 on the next edge; no strobe is ever emitted while frozen.
  - Resuming continues from the held accumulator with no lost or duplicated event.
- restart=1 (overrides hold): all acc=0, all phase=0, all strobes 0 on the next edge. The first post-restart ce_p is identical in timing to the first post-reset ce_p.
- Outputs are registered; ce_p and ce_n are never both high on one channel in the same cycle.
- Legality (elaboration-time check, error if violated):
  - DEN > 0.
  - 1 <= NUM.
  - 2*NUM <= DEN.
  - DEN < 2^ACC_W.
- NUM = DEN/2 (boundary): an event on every run cycle, so ce_p and ce_n alternate every clock at half clock rate.
- Channels are fully independent apart from the shared reset, power and restart.

Test Plan:
- Default params, reset released, power=1 from t0:
  - running rises at edge 2.
  - ch0 ce_p first high after 4th run edge, ce_n after 8th, ce_p after 12th; ce_p period 8, duty 1/8.
  - ch1 ce_p/ce_n alternate every clock.
- NUM=3, DEN=16 on ch0:
  - Over 1600 run cycles, exactly 300 ce_p and 300 ce_n.
  - ce_p spacing is only 5 or 6 clocks.
  - ce_p/ce_n strictly alternate.
- hold[0]=1 for 5 cycles mid-period:
  - No ch0 strobes during hold.
  - After release, the next ch0 ce_p lands exactly 5 clocks later than in the unheld reference run.
  - ch1 is unaffected.
- power dropped for 3 cycles:
  - Strobes stop 2 clocks after the drop.
  - They resume 2 clocks after return, with the accumulator preserved (event count matches the reference shifted by the outage).
- restart pulsed while ch0 acc=6, phase=1:
  - Strobes 0 next cycle.
  - The next ch0 event is ce_p (not ce_n), 4 run edges after restart deasserts.
- reset asserted asynchronously between clock edges while ce_p=1:
  - ce_p drops immediately and running=0.
  - After release with power=1, the sequence matches the first scenario exactly.
